// File: rtl/shift595_pkg.sv
// Shared definitions for the 74HC595 serial transmitter.
// Holds the FSM state encodings and the default frame geometry.
// The display top level uses these defaults.
package shift595_pkg;

  // Encodings are fixed so that the state can be probed on a debug header.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // Two cascaded '595 devices at sys_clk/8 shift rate.
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_CLK_DIV   = 4;
  localparam bit DEF_MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift595_tx.sv
// Purpose: shifts one parallel word out on ser_out/srclk to a '595 chain, then pulses rclk to latch it.
// Latency: frame busy for 2*CLK_DIV*DATA_W+CLK_DIV cycles after accept; done and tx_ready rise in the next cycle.
// Backpressure: tx_ready high only when idle; tx_valid while busy is ignored (no buffering).
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst_n     asynchronous active-low reset
//   tx_data   word to transmit, sampled only on the accept edge
//   tx_valid  tx_data valid
//   tx_ready  idle, a word can be accepted
//   done      1-cycle pulse once the frame has been shifted and latched
//   ser_out   serial data to '595 SER
//   srclk     shift clock to '595 SRCLK
//   rclk      latch clock to '595 RCLK
module shift595_tx
  import shift595_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              done,
  output logic              ser_out,
  output logic              srclk,
  output logic              rclk
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_ready_q, tx_ready_d;
  logic              done_q, done_d;
  logic              ser_q, ser_d;
  logic              srclk_q, srclk_d;
  logic              rclk_q, rclk_d;
  logic              accept;
  logic              phase_end;
  logic              cur_bit;

  assign accept    = tx_valid && tx_ready_q;
  assign phase_end = (div_cnt_q == DIV_LAST);

  // State and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
      ser_q      <= 1'b0;
      srclk_q    <= 1'b0;
      rclk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_ready_q <= tx_ready_d;
      done_q     <= done_d;
      ser_q      <= ser_d;
      srclk_q    <= srclk_d;
      rclk_q     <= rclk_d;
    end
  end

  // Next-state logic: every non-idle phase lasts exactly CLK_DIV cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_SETUP;
      ST_SETUP: if (phase_end) state_d = ST_HIGH;
      ST_HIGH:  if (phase_end) state_d = (bit_cnt_q == BIT_ONE) ? ST_LATCH : ST_SETUP;
      ST_LATCH: if (phase_end) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Divider, bit counter and shift register.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (state_d != state_q || state_q == ST_IDLE) begin
      div_cnt_d = '0;
    end

    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    if (accept) begin
      bit_cnt_d = BIT_LOAD;
      shreg_d   = tx_data;
    end else if (state_q == ST_HIGH && phase_end) begin
      // Advance after the srclk high phase so ser_out is stable across the rising edge.
      bit_cnt_d = bit_cnt_q - BIT_ONE;
      shreg_d   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end
  end

  // Outputs are decoded from the next state so the pins move on the same edge as the FSM.
  always_comb begin
    cur_bit    = MSB_FIRST ? shreg_d[DATA_W-1] : shreg_d[0];
    tx_ready_d = (state_d == ST_IDLE);
    done_d     = (state_q == ST_LATCH) && (state_d == ST_IDLE);
    srclk_d    = (state_d == ST_HIGH);
    rclk_d     = (state_d == ST_LATCH);
    ser_d      = 1'b0;
    if (state_d == ST_SETUP || state_d == ST_HIGH) begin
      ser_d = cur_bit;
    end
  end

  assign tx_ready = tx_ready_q;
  assign done     = done_q;
  assign ser_out  = ser_q;
  assign srclk    = srclk_q;
  assign rclk     = rclk_q;

endmodule

// File: tb/tb_shift595_tx.sv
// Bench for shift595_tx: three transmitter instances (MSB-first /4, LSB-first /4, MSB-first /1),
// each feeding a behavioural '595 chain (shift on srclk rise, latch on rclk rise).
// Directed scenarios with hand-computed expectations.
module tb_shift595_tx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] tx_data;
  logic        vld;
  int          sel;

  logic vld_a, rdy_a, done_a, ser_a, srclk_a, rclk_a;
  logic vld_l, rdy_l, done_l, ser_l, srclk_l, rclk_l;
  logic vld_f, rdy_f, done_f, ser_f, srclk_f, rclk_f;
  logic sel_done, sel_ser;

  assign vld_a = vld && (sel == 0);
  assign vld_l = vld && (sel == 1);
  assign vld_f = vld && (sel == 2);
  assign sel_done = (sel == 0) ? done_a : (sel == 1) ? done_l : done_f;
  assign sel_ser  = (sel == 0) ? ser_a  : (sel == 1) ? ser_l  : ser_f;

  shift595_tx #(.DATA_W(16), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld_a), .tx_ready(rdy_a),
    .done(done_a), .ser_out(ser_a), .srclk(srclk_a), .rclk(rclk_a));

  shift595_tx #(.DATA_W(16), .CLK_DIV(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld_l), .tx_ready(rdy_l),
    .done(done_l), .ser_out(ser_l), .srclk(srclk_l), .rclk(rclk_l));

  shift595_tx #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(1'b1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld_f), .tx_ready(rdy_f),
    .done(done_f), .ser_out(ser_f), .srclk(srclk_f), .rclk(rclk_f));

  // Behavioural '595 chains (not reset: the external part keeps its latch).
  logic [15:0] sr_a, lat_a, sr_l, lat_l, sr_f, lat_f;
  always @(posedge srclk_a) sr_a <= {sr_a[14:0], ser_a};
  always @(posedge rclk_a)  lat_a <= sr_a;
  always @(posedge srclk_l) sr_l <= {sr_l[14:0], ser_l};
  always @(posedge rclk_l)  lat_l <= sr_l;
  always @(posedge srclk_f) sr_f <= {sr_f[14:0], ser_f};
  always @(posedge rclk_f)  lat_f <= sr_f;

  int rise_a = 0, rise_l = 0, rise_f = 0;
  int rpul_a = 0, rpul_f = 0;
  int done_cnt_a = 0;
  int ovl = 0;
  always @(posedge srclk_a) rise_a <= rise_a + 1;
  always @(posedge srclk_l) rise_l <= rise_l + 1;
  always @(posedge srclk_f) rise_f <= rise_f + 1;
  always @(posedge rclk_a)  rpul_a <= rpul_a + 1;
  always @(posedge rclk_f)  rpul_f <= rpul_f + 1;
  always @(posedge clk) if (done_a) done_cnt_a <= done_cnt_a + 1;
  always @(negedge clk)
    if ((srclk_a && rclk_a) || (srclk_l && rclk_l) || (srclk_f && rclk_f)) ovl <= ovl + 1;

  int checks = 0;
  int errors = 0;

  // Send one word on the selected instance; returns the cycle (counted from the accept edge)
  // in which done is seen, or -1 on timeout, plus the first serial bit.
  task automatic tx(input int which, input logic [15:0] d, output int lat, output logic fb);
    sel = which;
    @(negedge clk);
    tx_data = d;
    vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    tx_data = 16'h0000;
    @(negedge clk);
    fb = sel_ser;
    lat = -1;
    for (int k = 1; k <= 1000; k++) begin
      if (sel_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int r0, c0;
    rst_n = 1'b0; vld = 1'b0; tx_data = 16'h0000; sel = 0;
    repeat (3) @(negedge clk);
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy_a); end
    checks++; if ({srclk_a, rclk_a, ser_a, done_a} !== 4'b0000) begin
      errors++; $display("FAIL reset_outs: got %b want 0000", {srclk_a, rclk_a, ser_a, done_a}); end
    checks++; if ({rdy_l, rdy_f} !== 2'b11) begin
      errors++; $display("FAIL reset_ready_others: got %b want 11", {rdy_l, rdy_f}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    r0 = rise_a; c0 = rpul_a;
    repeat (20) @(negedge clk);
    checks++; if (rise_a - r0 !== 0) begin errors++; $display("FAIL idle_srclk: got %0d want 0", rise_a - r0); end
    checks++; if (rpul_a - c0 !== 0) begin errors++; $display("FAIL idle_rclk: got %0d want 0", rpul_a - c0); end
    checks++; if ({srclk_a, rclk_a, ser_a, rdy_a} !== 4'b0001) begin
      errors++; $display("FAIL idle_outs: got %b want 0001", {srclk_a, rclk_a, ser_a, rdy_a}); end
  endtask

  task automatic test_frame();
    int r0, c0, lat; logic fb;
    r0 = rise_a; c0 = rpul_a;
    tx(0, 16'hA5C3, lat, fb);
    checks++; if (lat !== 133) begin errors++; $display("FAIL frame_latency: got %0d want 133", lat); end
    checks++; if (fb !== 1'b1) begin errors++; $display("FAIL frame_first_bit: got %b want 1", fb); end
    checks++; if (lat_a !== 16'hA5C3) begin errors++; $display("FAIL frame_latch: got %h want a5c3", lat_a); end
    checks++; if (rise_a - r0 !== 16) begin errors++; $display("FAIL frame_srclk: got %0d want 16", rise_a - r0); end
    checks++; if (rpul_a - c0 !== 1) begin errors++; $display("FAIL frame_rclk: got %0d want 1", rpul_a - c0); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL frame_ready: got %b want 1", rdy_a); end
  endtask

  task automatic test_lsb_first();
    int r0, lat; logic fb;
    r0 = rise_l;
    tx(1, 16'h0001, lat, fb);
    checks++; if (fb !== 1'b1) begin errors++; $display("FAIL lsb_first_bit: got %b want 1", fb); end
    checks++; if (lat_l !== 16'h8000) begin errors++; $display("FAIL lsb_latch: got %h want 8000", lat_l); end
    checks++; if (lat !== 133) begin errors++; $display("FAIL lsb_latency: got %0d want 133", lat); end
    checks++; if (rise_l - r0 !== 16) begin errors++; $display("FAIL lsb_srclk: got %0d want 16", rise_l - r0); end
  endtask

  task automatic test_busy();
    int d0, k;
    sel = 0;
    d0 = done_cnt_a;
    @(negedge clk);
    tx_data = 16'h1234; vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0; tx_data = 16'h0000;
    repeat (40) @(posedge clk);
    #1 vld = 1'b1; tx_data = 16'hFFFF;
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", rdy_a); end
    @(posedge clk);
    #1 vld = 1'b0; tx_data = 16'h0000;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done_a) break;
    end
    checks++; if (k >= 1000) begin errors++; $display("FAIL busy_done_timeout: got none want done"); end
    repeat (200) @(negedge clk);
    checks++; if (lat_a !== 16'h1234) begin errors++; $display("FAIL busy_latch: got %h want 1234", lat_a); end
    checks++; if (done_cnt_a - d0 !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", done_cnt_a - d0); end
  endtask

  task automatic test_back_to_back();
    int r0, c0, lat1, lat2;
    sel = 0;
    r0 = rise_a; c0 = rpul_a;
    @(negedge clk);
    tx_data = 16'h00FF; vld = 1'b1;
    @(posedge clk);
    lat1 = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (done_a) begin lat1 = k; break; end
    end
    checks++; if (lat1 !== 133) begin errors++; $display("FAIL b2b_latency1: got %0d want 133", lat1); end
    checks++; if (lat_a !== 16'h00FF) begin errors++; $display("FAIL b2b_latch1: got %h want 00ff", lat_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_done: got %b want 1", rdy_a); end
    tx_data = 16'hFF00;
    @(posedge clk);
    #1 vld = 1'b0; tx_data = 16'h0000;
    @(negedge clk);
    checks++; if ({rdy_a, done_a} !== 2'b00) begin
      errors++; $display("FAIL b2b_second_accept: got %b want 00", {rdy_a, done_a}); end
    lat2 = -1;
    for (int k = 1; k <= 1000; k++) begin
      if (done_a) begin lat2 = k; break; end
      @(negedge clk);
    end
    checks++; if (lat2 !== 133) begin errors++; $display("FAIL b2b_latency2: got %0d want 133", lat2); end
    checks++; if (lat_a !== 16'hFF00) begin errors++; $display("FAIL b2b_latch2: got %h want ff00", lat_a); end
    checks++; if (rise_a - r0 !== 32) begin errors++; $display("FAIL b2b_srclk: got %0d want 32", rise_a - r0); end
    checks++; if (rpul_a - c0 !== 2) begin errors++; $display("FAIL b2b_rclk: got %0d want 2", rpul_a - c0); end
  endtask

  task automatic test_reset_mid_frame();
    int r0, c0, lat; logic fb;
    tx(0, 16'h5555, lat, fb);
    checks++; if (lat_a !== 16'h5555) begin errors++; $display("FAIL mid_pre_latch: got %h want 5555", lat_a); end
    r0 = rise_a; c0 = rpul_a;
    sel = 0;
    @(negedge clk);
    tx_data = 16'hAAAA; vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0; tx_data = 16'h0000;
    // Cycle 66: setup phase of the ninth bit, which is a 1 for 16'hAAAA.
    repeat (65) @(posedge clk);
    #1;
    checks++; if ({ser_a, srclk_a} !== 2'b10) begin
      errors++; $display("FAIL mid_bit8_setup: got %b want 10", {ser_a, srclk_a}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ser_a, srclk_a, rclk_a, done_a, rdy_a} !== 5'b00001) begin
      errors++; $display("FAIL mid_async_reset: got %b want 00001", {ser_a, srclk_a, rclk_a, done_a, rdy_a}); end
    checks++; if (rise_a - r0 !== 8) begin errors++; $display("FAIL mid_srclk: got %0d want 8", rise_a - r0); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rpul_a - c0 !== 0) begin errors++; $display("FAIL mid_no_rclk: got %0d want 0", rpul_a - c0); end
    checks++; if (lat_a !== 16'h5555) begin errors++; $display("FAIL mid_latch_kept: got %h want 5555", lat_a); end
    tx(0, 16'h0F0F, lat, fb);
    checks++; if (lat_a !== 16'h0F0F) begin errors++; $display("FAIL mid_next_latch: got %h want 0f0f", lat_a); end
    checks++; if (lat !== 133) begin errors++; $display("FAIL mid_next_latency: got %0d want 133", lat); end
  endtask

  task automatic test_clk_div1();
    int r0, c0, lat; logic fb;
    r0 = rise_f; c0 = rpul_f;
    tx(2, 16'hA5C3, lat, fb);
    checks++; if (lat !== 34) begin errors++; $display("FAIL div1_latency: got %0d want 34", lat); end
    checks++; if (fb !== 1'b1) begin errors++; $display("FAIL div1_first_bit: got %b want 1", fb); end
    checks++; if (lat_f !== 16'hA5C3) begin errors++; $display("FAIL div1_latch: got %h want a5c3", lat_f); end
    checks++; if (rise_f - r0 !== 16) begin errors++; $display("FAIL div1_srclk: got %0d want 16", rise_f - r0); end
    checks++; if (rpul_f - c0 !== 1) begin errors++; $display("FAIL div1_rclk: got %0d want 1", rpul_f - c0); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_lsb_first();
    test_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_clk_div1();
    checks++; if (ovl !== 0) begin errors++; $display("FAIL srclk_rclk_overlap: got %0d want 0", ovl); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
